// File: rtl/display_pkg.sv
// Shared types for the seven-segment scan controller.
package display_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while running with the count at zero, and the
// owning FSM reloads it on that cycle, so done appears as a single-cycle pulse.
module scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             reload,
    input  logic [WIDTH-1:0] reload_value,
    input  logic             run,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            count <= '0;
        end else if (reload) begin
            count <= reload_value;
        end else if (run && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = run && (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS digits through one shared decoder: blank all anodes while the decoder
// settles on the new nibble, then light one anode; display value is double-buffered.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] displayValue,
    input  logic [NUM_DIGITS-1:0]        errorMask,
    output logic                         loadAck,
    output logic                         frameStart,
    output logic [NIBBLE_W-1:0]          binaryNumber,
    output logic                         isError,
    output logic [NUM_DIGITS-1:0]        digitEnable
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VALUE_W    = NIBBLE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state;
    logic [IDX_W-1:0]          idx;
    logic [VALUE_W-1:0]        active_value, shadow_value, commit_value, src_value;
    logic [NUM_DIGITS-1:0]     active_mask, shadow_mask, commit_mask, src_mask;
    logic                      pending;

    logic                      timer_done, timer_reload;
    logic [TIMER_W-1:0]        timer_value;
    logic                      enter_blank, frame_start, commit;
    logic [IDX_W-1:0]          next_idx;
    logic [NIBBLE_W-1:0]       next_number;
    logic                      next_error;

    assign enter_blank = enable && (state == IDLE || (state == SHOW && timer_done));
    assign frame_start = enter_blank && (state == IDLE || idx == LAST_IDX);
    assign commit      = frame_start && (pending || load);

    // The timer restarts on every state change; dropping enable parks it at zero.
    assign timer_reload = !enable || enter_blank || (state == BLANK && timer_done);
    assign timer_value  = !enable    ? '0 :
                          enter_blank ? TIMER_W'(BLANK_CYCLES - 1) :
                                        TIMER_W'(DWELL_CYCLES - 1);

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        commit_value = load ? displayValue : shadow_value;
        commit_mask  = load ? errorMask : shadow_mask;
        src_value    = commit ? commit_value : active_value;
        src_mask     = commit ? commit_mask : active_mask;
        next_idx     = frame_start ? '0 : idx + 1'b1;
        next_number  = src_value[int'(next_idx) * NIBBLE_W +: NIBBLE_W];
        next_error   = src_mask[next_idx];
    end

    scan_timer #(.WIDTH(TIMER_W)) u_timer (
        .clock        (clock),
        .resetN       (resetN),
        .reload       (timer_reload),
        .reload_value (timer_value),
        .run          (state != IDLE),
        .done         (timer_done)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state        <= IDLE;
            idx          <= '0;
            active_value <= '0;
            active_mask  <= '0;
            shadow_value <= '0;
            shadow_mask  <= '0;
            pending      <= 1'b0;
            loadAck      <= 1'b0;
            frameStart   <= 1'b0;
            binaryNumber <= '0;
            isError      <= 1'b0;
            digitEnable  <= '0;
        end else begin
            loadAck    <= commit;
            frameStart <= frame_start;

            if (load) begin
                shadow_value <= displayValue;
                shadow_mask  <= errorMask;
            end
            if (commit) begin
                active_value <= commit_value;
                active_mask  <= commit_mask;
                pending      <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (!enable) begin
                state       <= IDLE;
                idx         <= '0;
                digitEnable <= '0;
            end else if (enter_blank) begin
                state        <= BLANK;
                idx          <= next_idx;
                digitEnable  <= '0;
                binaryNumber <= next_number;
                isError      <= next_error;
            end else if (state == BLANK && timer_done) begin
                state       <= SHOW;
                digitEnable <= NUM_DIGITS'(1) << idx;
            end
        end
    end

endmodule
